// File: rtl/input_mem_sched.sv
// Diagonal-skew read scheduler for a bank-per-row systolic input memory, plus the
// loader write path that is locked out while a sweep is in flight.
module input_mem_sched #(
    parameter int SYS_ROW    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 8,
    localparam int BW        = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic [ADDR_W-1:0]                    base_addr,
    input  logic [ADDR_W:0]                      len,
    output logic                                 busy,
    output logic                                 done,
    input  logic                                 wr_valid,
    input  logic [BW-1:0]                        wr_bank,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic                                 wr_ready,
    output logic [SYS_ROW-1:0]                   mem_rd_en,
    output logic [SYS_ROW-1:0][ADDR_W-1:0]       mem_rd_addr,
    output logic [SYS_ROW-1:0]                   mem_wr_en,
    output logic [SYS_ROW-1:0][ADDR_W-1:0]       mem_wr_addr,
    output logic [SYS_ROW-1:0][DATA_WIDTH-1:0]   mem_wr_data,
    output logic [SYS_ROW-1:0]                   data_valid
);

    localparam int TW = ADDR_W + BW + 2;
    localparam logic [ADDR_W:0] MAX_L = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t                          state_q;
    logic [TW-1:0]                   t_q;
    logic [ADDR_W:0]                 l_q;
    logic [ADDR_W-1:0]               base_q;

    logic [ADDR_W:0]                 len_clip;
    logic [ADDR_W-1:0]               sel_base;
    logic [ADDR_W:0]                 sel_len;
    logic [TW-1:0]                   sel_t;
    logic [TW-1:0]                   last_t;
    logic [SYS_ROW-1:0]              sched_en;
    logic [SYS_ROW-1:0][ADDR_W-1:0]  sched_addr;
    logic                            wr_accept;

    // Schedule for the cycle after the next edge: from the inputs when launching,
    // otherwise from the latched sweep at t+1.
    always_comb begin
        len_clip = (len > MAX_L) ? MAX_L : len;
        last_t   = TW'(l_q) + TW'(SYS_ROW - 2);
        if (state_q == StIdle) begin
            sel_base = base_addr;
            sel_len  = len_clip;
            sel_t    = '0;
        end else begin
            sel_base = base_q;
            sel_len  = l_q;
            sel_t    = t_q + TW'(1);
        end
        sched_en   = '0;
        sched_addr = '0;
        for (int i = 0; i < SYS_ROW; i++) begin
            if ((sel_t >= TW'(i)) && (sel_t < TW'(i) + TW'(sel_len))) begin
                sched_en[i]   = 1'b1;
                sched_addr[i] = sel_base + ADDR_W'(sel_t - TW'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            t_q         <= '0;
            l_q         <= '0;
            base_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= '0;
            mem_rd_addr <= '0;
            data_valid  <= '0;
        end else begin
            data_valid <= mem_rd_en;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q <= base_addr;
                        l_q    <= len_clip;
                        t_q    <= '0;
                        busy   <= 1'b1;
                        if (len_clip == '0) begin
                            state_q <= StDrain;
                            done    <= 1'b1;
                        end else begin
                            state_q     <= StRun;
                            mem_rd_en   <= sched_en;
                            mem_rd_addr <= sched_addr;
                        end
                    end
                end
                StRun: begin
                    if (t_q == last_t) begin
                        state_q     <= StDrain;
                        done        <= 1'b1;
                        mem_rd_en   <= '0;
                        mem_rd_addr <= '0;
                    end else begin
                        t_q         <= t_q + TW'(1);
                        mem_rd_en   <= sched_en;
                        mem_rd_addr <= sched_addr;
                    end
                end
                StDrain: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_ready  = rstn && !busy;
    assign wr_accept = wr_valid && wr_ready;

    // Out-of-range bank numbers are accepted but produce no write strobe.
    always_comb begin
        mem_wr_en   = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        if (wr_accept && (32'(wr_bank) < SYS_ROW)) begin
            mem_wr_en[wr_bank]   = 1'b1;
            mem_wr_addr[wr_bank] = wr_addr;
            mem_wr_data[wr_bank] = wr_data;
        end
    end

endmodule

// File: tb/tb_input_mem_sched.sv
// Randomised self-checking bench for input_mem_sched; expectations come from a
// per-cycle model of the sweep rules (bank i reads word k-i while 0 <= k-i < L).
module tb_input_mem_sched;

    localparam int SR = 16;
    localparam int DW = 16;
    localparam int AW = 8;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     start;
    logic [AW-1:0]            base_addr;
    logic [AW:0]              len;
    logic                     busy, done;
    logic                     wr_valid;
    logic [3:0]               wr_bank;
    logic [AW-1:0]            wr_addr;
    logic [DW-1:0]            wr_data;
    logic                     wr_ready;
    logic [SR-1:0]            mem_rd_en;
    logic [SR-1:0][AW-1:0]    mem_rd_addr;
    logic [SR-1:0]            mem_wr_en;
    logic [SR-1:0][AW-1:0]    mem_wr_addr;
    logic [SR-1:0][DW-1:0]    mem_wr_data;
    logic [SR-1:0]            data_valid;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    input_mem_sched #(.SYS_ROW(SR), .DATA_WIDTH(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .wr_valid(wr_valid), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .data_valid(data_valid)
    );

    // Launch a sweep and check every busy cycle against the model. restart_at injects
    // a second start in cycle k; abort_at pulls reset in cycle k and returns.
    task automatic run_sweep(input logic [AW-1:0] b, input int ln, input int restart_at,
                             input int abort_at);
        int l, nrun;
        logic [SR-1:0]         exp_en, prev_en;
        logic [SR-1:0][AW-1:0] exp_addr;
        logic [SR-1:0]         exp_wr;
        l    = (ln > 256) ? 256 : ln;
        nrun = (l == 0) ? 0 : l + SR - 1;
        @(negedge clk);
        start = 1'b1; base_addr = b; len = (AW+1)'(ln);
        #1;
        exp_wr = (wr_valid && wr_bank < SR) ? (SR'(1) << wr_bank) : '0;
        vectors++;
        if (mem_wr_en !== exp_wr) begin
            errors++;
            $display("FAIL launch_write: mem_wr_en got %h want %h", mem_wr_en, exp_wr);
        end
        @(negedge clk);
        start = 1'b0;
        prev_en = '0;
        for (int k = 0; k <= nrun; k++) begin
            if (k == restart_at + 1) start = 1'b0;
            for (int i = 0; i < SR; i++) begin
                exp_en[i]   = (k < nrun) && (k >= i) && (k - i < l);
                exp_addr[i] = exp_en[i] ? AW'(int'(b) + k - i) : '0;
            end
            vectors++;
            if (busy !== 1'b1 || done !== (k == nrun) || wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL sweep_ctl k=%0d: busy/done/wr_ready got %b%b%b want 1%b0",
                         k, busy, done, wr_ready, k == nrun);
            end
            vectors++;
            if (mem_rd_en !== exp_en || mem_rd_addr !== exp_addr) begin
                errors++;
                $display("FAIL sweep_rd k=%0d: en %h addr %h want en %h addr %h",
                         k, mem_rd_en, mem_rd_addr, exp_en, exp_addr);
            end
            vectors++;
            if (data_valid !== prev_en || mem_wr_en !== '0) begin
                errors++;
                $display("FAIL sweep_dv k=%0d: dv %h wr_en %h want dv %h wr_en 0",
                         k, data_valid, mem_wr_en, prev_en);
            end
            prev_en = exp_en;
            if (k == restart_at) begin
                start = 1'b1; base_addr = 8'h55; len = 9'd7;
            end
            if (k == abort_at) begin
                rstn = 1'b0;
                #1;
                vectors++;
                if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== '0 ||
                    mem_rd_addr !== '0 || data_valid !== '0 || wr_ready !== 1'b0 ||
                    mem_wr_en !== '0) begin
                    errors++;
                    $display("FAIL abort k=%0d: busy %b done %b en %h addr %h dv %h rdy %b",
                             k, busy, done, mem_rd_en, mem_rd_addr, data_valid, wr_ready);
                end
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        exp_wr = (wr_valid && wr_bank < SR) ? (SR'(1) << wr_bank) : '0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || data_valid !== '0 || wr_ready !== 1'b1 ||
            mem_wr_en !== exp_wr) begin
            errors++;
            $display("FAIL sweep_end: busy %b done %b dv %h rdy %b wr_en %h want 0 0 0 1 %h",
                     busy, done, data_valid, wr_ready, mem_wr_en, exp_wr);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        wr_valid = 1'b1; wr_bank = 4'd2; wr_addr = 8'h11; wr_data = 16'h1234;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== '0 || mem_rd_addr !== '0 ||
            data_valid !== '0 || wr_ready !== 1'b0 || mem_wr_en !== '0) begin
            errors++;
            $display("FAIL reset: busy %b done %b en %h dv %h rdy %b wr_en %h",
                     busy, done, mem_rd_en, data_valid, wr_ready, mem_wr_en);
        end
        rstn = 1'b1;
        #1;
        vectors++;
        if (wr_ready !== 1'b1 || mem_wr_en !== 16'h0004) begin
            errors++;
            $display("FAIL reset_release: rdy %b wr_en %h want 1 0004", wr_ready, mem_wr_en);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_sweep(8'h10, 4, -1, -1);
    endtask

    task automatic test_wrap();
        run_sweep(8'hFE, 4, -1, -1);
    endtask

    task automatic test_len_edges();
        run_sweep(8'h33, 0, -1, -1);
        run_sweep(8'h80, 300, -1, -1);
        run_sweep(8'h01, 256, -1, -1);
        run_sweep(8'h07, 1, -1, -1);
    endtask

    task automatic test_write();
        logic [SR-1:0] exp;
        @(negedge clk);
        wr_valid = 1'b1; wr_bank = 4'd3; wr_addr = 8'h20; wr_data = 16'hBEEF;
        #1;
        vectors++;
        if (mem_wr_en !== 16'h0008 || mem_wr_addr[3] !== 8'h20 ||
            mem_wr_data[3] !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_b3: en %h addr %h data %h want 0008 20 beef",
                     mem_wr_en, mem_wr_addr[3], mem_wr_data[3]);
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            wr_valid = 1'($urandom_range(0, 3) != 0);
            wr_bank  = 4'($urandom);
            wr_addr  = 8'($urandom);
            wr_data  = 16'($urandom);
            #1;
            exp = wr_valid ? (SR'(1) << wr_bank) : '0;
            vectors++;
            if (mem_wr_en !== exp ||
                (wr_valid && (mem_wr_addr[wr_bank] !== wr_addr ||
                              mem_wr_data[wr_bank] !== wr_data))) begin
                errors++;
                $display("FAIL write_rand n=%0d: en %h want %h bank %0d", n, mem_wr_en, exp,
                         wr_bank);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_busy_lockout();
        wr_valid = 1'b1; wr_bank = 4'd9; wr_addr = 8'hA5; wr_data = 16'h5A5A;
        run_sweep(8'h40, 3, -1, -1);
        wr_valid = 1'b0;
    endtask

    task automatic test_restart_ignored();
        run_sweep(8'h10, 4, 5, -1);
    endtask

    task automatic test_reset_mid();
        run_sweep(8'h10, 4, -1, 7);
        @(negedge clk);
        rstn = 1'b1;
        run_sweep(8'h10, 4, -1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int ln;
            ln = (n % 5 == 4) ? $urandom_range(0, 511) : $urandom_range(0, 40);
            wr_valid = 1'($urandom_range(0, 1));
            wr_bank  = 4'($urandom);
            run_sweep(8'($urandom), ln, -1, -1);
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len_edges();
        test_write();
        test_busy_lockout();
        test_restart_ignored();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
